// File: rtl/lcd_rx_pkg.sv
// Shared definitions for the serial LCD link receiver: command opcodes,
// decoder state encoding and RGB565 field widths.
package lcd_rx_pkg;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_RASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  localparam int RED_W   = 5;
  localparam int GREEN_W = 6;
  localparam int BLUE_W  = 5;

  typedef enum logic [2:0] {
    IDLE,
    PIX_HI,
    PIX_LO,
    WIN_B0,
    WIN_B1,
    WIN_B2,
    WIN_B3
  } rx_state_t;

endpackage

// File: rtl/lcd_spi_deser.sv
// Byte deserialiser for the serial LCD link: pin synchronisers, scl rising
// edge detection, MSB-first shift register with 3-bit bit counter, and
// detection of chip-select release in the middle of a byte.
module lcd_spi_deser
  import lcd_rx_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sda,
  input  logic       scl,
  input  logic       cs,
  input  logic       rs,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_is_data,
  output logic       err_abort
);

  logic [SYNC_STAGES-1:0] sda_sync, scl_sync, cs_sync, rs_sync;
  logic       scl_d, cs_d;
  logic [7:0] shift;
  logic [2:0] bit_cnt;
  logic       done, rs_lat;

  logic sda_s, scl_s, cs_s, rs_s;
  logic scl_rise, cs_rise, bit_en, last_bit;

  assign sda_s = sda_sync[SYNC_STAGES-1];
  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign cs_s  = cs_sync[SYNC_STAGES-1];
  assign rs_s  = rs_sync[SYNC_STAGES-1];

  assign scl_rise = scl_s & ~scl_d;
  assign cs_rise  = cs_s & ~cs_d;
  // A bit is still accepted when cs releases on the same cycle as the scl
  // edge, so a byte whose 8th edge coincides with cs release completes.
  assign bit_en   = scl_rise & (~cs_s | cs_rise);
  assign last_bit = bit_en & (bit_cnt == 3'd7);

  // Synchronise pins, shift bits in, and flag complete or aborted bytes.
  always_ff @(posedge clk) begin
    if (reset) begin
      sda_sync     <= '0;
      scl_sync     <= '0;
      cs_sync      <= '0;
      rs_sync      <= '0;
      scl_d        <= 1'b0;
      cs_d         <= 1'b0;
      shift        <= '0;
      bit_cnt      <= '0;
      done         <= 1'b0;
      rs_lat       <= 1'b0;
      byte_valid   <= 1'b0;
      byte_data    <= '0;
      byte_is_data <= 1'b0;
      err_abort    <= 1'b0;
    end else begin
      sda_sync[0] <= sda;
      scl_sync[0] <= scl;
      cs_sync[0]  <= cs;
      rs_sync[0]  <= rs;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sda_sync[i] <= sda_sync[i-1];
        scl_sync[i] <= scl_sync[i-1];
        cs_sync[i]  <= cs_sync[i-1];
        rs_sync[i]  <= rs_sync[i-1];
      end
      scl_d <= scl_s;
      cs_d  <= cs_s;

      byte_valid <= done;
      done       <= 1'b0;
      err_abort  <= 1'b0;
      if (done) begin
        byte_data    <= shift;
        byte_is_data <= rs_lat;
      end

      if (bit_en) begin
        shift   <= {shift[6:0], sda_s};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          done   <= 1'b1;
          rs_lat <= rs_s;
        end
      end

      // Releasing cs always realigns the byte boundary; a partial byte is lost.
      if (cs_rise) begin
        bit_cnt <= '0;
        if (!last_bit && (bit_cnt != 3'd0 || bit_en))
          err_abort <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/lcd_spi_rx.sv
// Receiver for the 4-wire serial LCD link (sda/scl/cs/rs). Deserialises
// bytes, decodes RAMWR and rebuilds RGB565 pixels with their window position.
// Optional feature macro: LCD_RX_WINDOW_EN enables CASET/RASET decoding so
// the pixel window is programmable; without it the window is the full panel.
module lcd_spi_rx
  import lcd_rx_pkg::*;
#(
  parameter int H_RES       = 160,
  parameter int V_RES       = 128,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sda,
  input  logic               scl,
  input  logic               cs,
  input  logic               rs,
  output logic               byte_valid,
  output logic [7:0]         byte_data,
  output logic               byte_is_data,
  output logic               pix_valid,
  output logic [RED_W-1:0]   red,
  output logic [GREEN_W-1:0] green,
  output logic [BLUE_W-1:0]  blue,
  output logic [7:0]         hpos,
  output logic [6:0]         vpos,
  output logic               frame_start,
  output logic               frame_done,
  output logic               err_abort
);

  localparam logic [7:0] X_LAST = 8'(H_RES - 1);
  localparam logic [6:0] Y_LAST = 7'(V_RES - 1);

  logic link_abort, fsm_abort;

  lcd_spi_deser #(.SYNC_STAGES(SYNC_STAGES)) u_deser (
    .clk          (clk),
    .reset        (reset),
    .sda          (sda),
    .scl          (scl),
    .cs           (cs),
    .rs           (rs),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_is_data (byte_is_data),
    .err_abort    (link_abort)
  );

  assign err_abort = link_abort | fsm_abort;

  rx_state_t          state, state_nx;
  logic [7:0]         hi_byte, hi_nx;
  logic [7:0]         pos_x, pos_x_nx;
  logic [6:0]         pos_y, pos_y_nx;
  logic               pix_nx, fs_nx, fd_nx, abort_nx;
  logic [RED_W-1:0]   red_nx;
  logic [GREEN_W-1:0] green_nx;
  logic [BLUE_W-1:0]  blue_nx;
  logic [7:0]         hpos_nx;
  logic [6:0]         vpos_nx;
  logic [7:0]         x_start, x_end;
  logic [6:0]         y_start, y_end;

`ifdef LCD_RX_WINDOW_EN
  logic       win_row, win_row_nx;
  logic [7:0] win_lo, win_lo_nx;
  logic [7:0] x_start_nx, x_end_nx;
  logic [6:0] y_start_nx, y_end_nx;

  // Window bounds and the CASET/RASET capture registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      win_row <= 1'b0;
      win_lo  <= '0;
      x_start <= '0;
      x_end   <= X_LAST;
      y_start <= '0;
      y_end   <= Y_LAST;
    end else begin
      win_row <= win_row_nx;
      win_lo  <= win_lo_nx;
      x_start <= x_start_nx;
      x_end   <= x_end_nx;
      y_start <= y_start_nx;
      y_end   <= y_end_nx;
    end
  end
`else
  assign x_start = '0;
  assign x_end   = X_LAST;
  assign y_start = '0;
  assign y_end   = Y_LAST;
`endif

  // Decoder state, position counters and registered pixel outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      hi_byte     <= '0;
      pos_x       <= '0;
      pos_y       <= '0;
      pix_valid   <= 1'b0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      hpos        <= '0;
      vpos        <= '0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      fsm_abort   <= 1'b0;
    end else begin
      state       <= state_nx;
      hi_byte     <= hi_nx;
      pos_x       <= pos_x_nx;
      pos_y       <= pos_y_nx;
      pix_valid   <= pix_nx;
      red         <= red_nx;
      green       <= green_nx;
      blue        <= blue_nx;
      hpos        <= hpos_nx;
      vpos        <= vpos_nx;
      frame_start <= fs_nx;
      frame_done  <= fd_nx;
      fsm_abort   <= abort_nx;
    end
  end

  // Next-state and next-output decode, advanced only by received bytes.
  always_comb begin
    state_nx = state;
    hi_nx    = hi_byte;
    pos_x_nx = pos_x;
    pos_y_nx = pos_y;
    pix_nx   = 1'b0;
    fs_nx    = 1'b0;
    fd_nx    = 1'b0;
    abort_nx = 1'b0;
    red_nx   = red;
    green_nx = green;
    blue_nx  = blue;
    hpos_nx  = hpos;
    vpos_nx  = vpos;
`ifdef LCD_RX_WINDOW_EN
    win_row_nx = win_row;
    win_lo_nx  = win_lo;
    x_start_nx = x_start;
    x_end_nx   = x_end;
    y_start_nx = y_start;
    y_end_nx   = y_end;
`endif
    if (byte_valid) begin
      if (!byte_is_data) begin
        // A command cuts short a pixel or window update in progress.
        if (state != IDLE && state != PIX_HI)
          abort_nx = 1'b1;
        state_nx = IDLE;
        if (byte_data == CMD_RAMWR) begin
          state_nx = PIX_HI;
          pos_x_nx = x_start;
          pos_y_nx = y_start;
          fs_nx    = 1'b1;
        end
`ifdef LCD_RX_WINDOW_EN
        else if (byte_data == CMD_CASET) begin
          state_nx   = WIN_B0;
          win_row_nx = 1'b0;
        end else if (byte_data == CMD_RASET) begin
          state_nx   = WIN_B0;
          win_row_nx = 1'b1;
        end
`endif
      end else begin
        case (state)
          PIX_HI: begin
            hi_nx    = byte_data;
            state_nx = PIX_LO;
          end
          PIX_LO: begin
            pix_nx   = 1'b1;
            red_nx   = hi_byte[7:3];
            green_nx = {hi_byte[2:0], byte_data[7:5]};
            blue_nx  = byte_data[4:0];
            hpos_nx  = pos_x;
            vpos_nx  = pos_y;
            state_nx = PIX_HI;
            if (pos_x == x_end) begin
              pos_x_nx = x_start;
              if (pos_y == y_end) begin
                pos_y_nx = y_start;
                fd_nx    = 1'b1;
              end else begin
                pos_y_nx = pos_y + 7'd1;
              end
            end else begin
              pos_x_nx = pos_x + 8'd1;
            end
          end
`ifdef LCD_RX_WINDOW_EN
          // Only the low byte of each 16-bit coordinate is kept.
          WIN_B0: state_nx = WIN_B1;
          WIN_B1: begin
            win_lo_nx = byte_data;
            state_nx  = WIN_B2;
          end
          WIN_B2: state_nx = WIN_B3;
          WIN_B3: begin
            state_nx = IDLE;
            if (win_row) begin
              y_start_nx = win_lo[6:0];
              y_end_nx   = byte_data[6:0];
            end else begin
              x_start_nx = win_lo;
              x_end_nx   = byte_data;
            end
          end
`endif
          default: state_nx = state;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lcd_spi_rx.sv
// Bench for lcd_spi_rx: a full-size instance plus a 4x3 instance sharing the
// same pins so frame wrap can be exercised in a short run.
module tb_lcd_spi_rx;

  logic clk = 1'b0;
  logic reset, sda, scl, cs, rs;

  logic       byte_valid, byte_is_data, pix_valid, frame_start, frame_done, err_abort;
  logic [7:0] byte_data, hpos;
  logic [4:0] red, blue;
  logic [5:0] green;
  logic [6:0] vpos;

  logic       s_byte_valid, s_byte_is_data, s_pix_valid, s_frame_start, s_frame_done, s_err_abort;
  logic [7:0] s_byte_data, s_hpos;
  logic [4:0] s_red, s_blue;
  logic [5:0] s_green;
  logic [6:0] s_vpos;

  always #5 clk = ~clk;

  lcd_spi_rx dut (
    .clk(clk), .reset(reset), .sda(sda), .scl(scl), .cs(cs), .rs(rs),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_is_data(byte_is_data),
    .pix_valid(pix_valid), .red(red), .green(green), .blue(blue),
    .hpos(hpos), .vpos(vpos), .frame_start(frame_start),
    .frame_done(frame_done), .err_abort(err_abort)
  );

  lcd_spi_rx #(.H_RES(4), .V_RES(3)) dut_small (
    .clk(clk), .reset(reset), .sda(sda), .scl(scl), .cs(cs), .rs(rs),
    .byte_valid(s_byte_valid), .byte_data(s_byte_data), .byte_is_data(s_byte_is_data),
    .pix_valid(s_pix_valid), .red(s_red), .green(s_green), .blue(s_blue),
    .hpos(s_hpos), .vpos(s_vpos), .frame_start(s_frame_start),
    .frame_done(s_frame_done), .err_abort(s_err_abort)
  );

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
    logic [7:0] h;
    logic [6:0] v;
    logic       fd;
  } pix_t;

  typedef struct {
    logic [7:0] hi;
    logic [7:0] lo;
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
    logic [7:0] h;
    logic [6:0] v;
  } vec_t;

  pix_t       pq[$];
  pix_t       sq[$];
  logic [8:0] bq[$];
  int fs_cnt = 0, ab_cnt = 0, sfd_cnt = 0;
  int n_chk = 0, n_pass = 0;
  vec_t vecs[5];

  // Capture every strobe from both instances on the inactive edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (byte_valid)   bq.push_back({byte_is_data, byte_data});
      if (pix_valid)    pq.push_back({red, green, blue, hpos, vpos, frame_done});
      if (s_pix_valid)  sq.push_back({s_red, s_green, s_blue, s_hpos, s_vpos, s_frame_done});
      if (frame_start)  fs_cnt++;
      if (err_abort)    ab_cnt++;
      if (s_frame_done) sfd_cnt++;
    end
  end

  function automatic logic [63:0] outvec();
    return 64'({byte_valid, byte_data, byte_is_data, pix_valid, red, green, blue,
                hpos, vpos, frame_start, frame_done, err_abort});
  endfunction

  function automatic logic [63:0] s_outvec();
    return 64'({s_byte_valid, s_byte_data, s_byte_is_data, s_pix_valid, s_red, s_green,
                s_blue, s_hpos, s_vpos, s_frame_start, s_frame_done, s_err_abort});
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n, input logic r);
    for (int i = 7; i > 7 - n; i--) begin
      sda = b[i];
      rs  = r;
      repeat (2) @(negedge clk);
      scl = 1'b1;
      repeat (2) @(negedge clk);
      scl = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic r);
    send_bits(b, 8, r);
  endtask

  task automatic settle();
    repeat (8) @(negedge clk);
  endtask

  task automatic pop_byte(input string nm, input logic [8:0] exp);
    if (bq.size() == 0) chk({nm, "_present"}, 0, 1);
    else chk(nm, 64'(bq.pop_front()), 64'(exp));
  endtask

  task automatic pop_pix(input string nm, output pix_t p);
    p = '0;
    if (pq.size() == 0) chk({nm, "_present"}, 0, 1);
    else p = pq.pop_front();
  endtask

  initial begin
    pix_t p, sp;
    int fs0, ab0, sfd0;
    logic [7:0] hi, lo;

    vecs[0] = '{8'hF8, 8'h00, 5'd31, 6'd0,  5'd0,  8'd0, 7'd0};
    vecs[1] = '{8'h07, 8'hE0, 5'd0,  6'd63, 5'd0,  8'd1, 7'd0};
    vecs[2] = '{8'h00, 8'h1F, 5'd0,  6'd0,  5'd31, 8'd2, 7'd0};
    vecs[3] = '{8'hA5, 8'h5A, 5'd20, 6'd42, 5'd26, 8'd3, 7'd0};
    vecs[4] = '{8'hFF, 8'hFF, 5'd31, 6'd63, 5'd31, 8'd4, 7'd0};

    reset = 1'b1; sda = 1'b0; scl = 1'b0; cs = 1'b1; rs = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", outvec(), 64'd0);
    chk("reset_outputs_small", s_outvec(), 64'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // RAMWR then table of pixels
    cs = 1'b0;
    fs0 = fs_cnt;
    send_byte(8'h2C, 1'b0);
    settle();
    chk("ramwr_frame_start", 64'(fs_cnt - fs0), 64'd1);
    pop_byte("ramwr_byte", {1'b0, 8'h2C});
    for (int k = 0; k < 5; k++) begin
      send_byte(vecs[k].hi, 1'b1);
      send_byte(vecs[k].lo, 1'b1);
      settle();
      pop_byte($sformatf("vec%0d_hi_byte", k), {1'b1, vecs[k].hi});
      pop_byte($sformatf("vec%0d_lo_byte", k), {1'b1, vecs[k].lo});
      pop_pix($sformatf("vec%0d_pix", k), p);
      chk($sformatf("vec%0d_rgb", k), 64'({p.r, p.g, p.b}), 64'({vecs[k].r, vecs[k].g, vecs[k].b}));
      chk($sformatf("vec%0d_pos", k), 64'({p.h, p.v, p.fd}), 64'({vecs[k].h, vecs[k].v, 1'b0}));
    end

    // Line wrap on the full panel and frame wrap on the 4x3 instance
    bq.delete(); pq.delete(); sq.delete();
    sfd0 = sfd_cnt;
    send_byte(8'h2C, 1'b0);
    for (int i = 0; i < 161; i++) begin
      send_byte(8'(i), 1'b1);
      send_byte(8'(i * 3), 1'b1);
    end
    settle();
    chk("line_pix_count", 64'(pq.size()), 64'd161);
    chk("small_pix_count", 64'(sq.size()), 64'd161);
    for (int i = 0; i < 161; i++) begin
      pop_pix($sformatf("line_pix%0d", i), p);
      chk($sformatf("line_pos%0d", i), 64'({p.h, p.v, p.fd}),
          64'({8'(i % 160), 7'(i / 160), 1'b0}));
      if (sq.size() == 0) chk($sformatf("small_pix%0d_present", i), 0, 1);
      else begin
        sp = sq.pop_front();
        chk($sformatf("small_pos%0d", i), 64'({sp.h, sp.v, sp.fd}),
            64'({8'(i % 4), 7'((i / 4) % 3), (i % 12) == 11}));
      end
      if (i == 160) begin
        hi = 8'(i); lo = 8'(i * 3);
        chk("line_last_rgb", 64'({p.r, p.g, p.b}), 64'({hi[7:3], hi[2:0], lo[7:5], lo[4:0]}));
      end
    end
    chk("small_frame_done_count", 64'(sfd_cnt - sfd0), 64'd13);

    // Partial byte then cs release
    bq.delete(); pq.delete();
    ab0 = ab_cnt;
    send_bits(8'hFF, 5, 1'b1);
    repeat (2) @(negedge clk);
    cs = 1'b1;
    settle();
    chk("partial_abort", 64'(ab_cnt - ab0), 64'd1);
    chk("partial_no_byte", 64'(bq.size()), 64'd0);
    cs = 1'b0;
    repeat (2) @(negedge clk);
    ab0 = ab_cnt;
    send_byte(8'hA5, 1'b0);
    settle();
    pop_byte("after_abort_byte", {1'b0, 8'hA5});
    chk("after_abort_no_err", 64'(ab_cnt - ab0), 64'd0);

    // Command between pixel bytes
    ab0 = ab_cnt; fs0 = fs_cnt;
    send_byte(8'h2C, 1'b0);
    send_byte(8'h12, 1'b1);
    send_byte(8'h00, 1'b0);
    send_byte(8'h34, 1'b1);
    send_byte(8'h56, 1'b1);
    settle();
    chk("split_pix_abort", 64'(ab_cnt - ab0), 64'd1);
    chk("split_pix_fs", 64'(fs_cnt - fs0), 64'd1);
    chk("split_pix_none", 64'(pq.size()), 64'd0);

    // cs released between the two bytes of a pixel
    ab0 = ab_cnt;
    send_byte(8'h2C, 1'b0);
    send_byte(8'h07, 1'b1);
    repeat (2) @(negedge clk);
    cs = 1'b1;
    repeat (10) @(negedge clk);
    cs = 1'b0;
    repeat (2) @(negedge clk);
    send_byte(8'hE0, 1'b1);
    settle();
    pop_pix("cs_gap_pix", p);
    chk("cs_gap_rgb", 64'({p.r, p.g, p.b, p.h, p.v}), 64'({5'd0, 6'd63, 5'd0, 8'd0, 7'd0}));
    chk("cs_gap_no_err", 64'(ab_cnt - ab0), 64'd0);

    // cs released on the same cycle as the 8th scl edge
    bq.delete();
    ab0 = ab_cnt;
    send_bits(8'h3C, 7, 1'b0);
    sda = 1'b0;
    repeat (2) @(negedge clk);
    scl = 1'b1;
    cs  = 1'b1;
    repeat (2) @(negedge clk);
    scl = 1'b0;
    settle();
    pop_byte("cs_last_edge_byte", {1'b0, 8'h3C});
    chk("cs_last_edge_no_err", 64'(ab_cnt - ab0), 64'd0);

    // Reset in the middle of a byte
    cs = 1'b0;
    repeat (2) @(negedge clk);
    send_bits(8'hF0, 3, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    chk("midbyte_reset_outputs", outvec(), 64'd0);
    chk("midbyte_reset_outputs_small", s_outvec(), 64'd0);
    reset = 1'b0;
    settle();
    pq.delete();
    ab0 = ab_cnt;
    send_byte(8'h2C, 1'b0);
    send_byte(8'hF8, 1'b1);
    send_byte(8'h00, 1'b1);
    settle();
    pop_pix("post_reset_pix", p);
    chk("post_reset_rgb_pos", 64'({p.r, p.g, p.b, p.h, p.v}), 64'({5'd31, 6'd0, 5'd0, 8'd0, 7'd0}));
    chk("post_reset_no_err", 64'(ab_cnt - ab0), 64'd0);

`ifdef LCD_RX_WINDOW_EN
    // Programmed window 10..11 x 5..5
    pq.delete();
    send_byte(8'h2A, 1'b0);
    send_byte(8'h00, 1'b1); send_byte(8'h0A, 1'b1);
    send_byte(8'h00, 1'b1); send_byte(8'h0B, 1'b1);
    send_byte(8'h2B, 1'b0);
    send_byte(8'h00, 1'b1); send_byte(8'h05, 1'b1);
    send_byte(8'h00, 1'b1); send_byte(8'h05, 1'b1);
    send_byte(8'h2C, 1'b0);
    for (int i = 0; i < 3; i++) begin
      send_byte(8'h12, 1'b1);
      send_byte(8'h34, 1'b1);
    end
    settle();
    pop_pix("win_pix0", p);
    chk("win_pos0", 64'({p.h, p.v, p.fd}), 64'({8'd10, 7'd5, 1'b0}));
    pop_pix("win_pix1", p);
    chk("win_pos1", 64'({p.h, p.v, p.fd}), 64'({8'd11, 7'd5, 1'b1}));
    pop_pix("win_pix2", p);
    chk("win_pos2", 64'({p.h, p.v, p.fd}), 64'({8'd10, 7'd5, 1'b0}));
    ab0 = ab_cnt;
    send_byte(8'h2A, 1'b0);
    send_byte(8'h00, 1'b1); send_byte(8'h14, 1'b1);
    send_byte(8'h2C, 1'b0);
    send_byte(8'h12, 1'b1); send_byte(8'h34, 1'b1);
    settle();
    chk("win_abort", 64'(ab_cnt - ab0), 64'd1);
    pop_pix("win_kept_pix", p);
    chk("win_kept_pos", 64'({p.h, p.v}), 64'({8'd10, 7'd5}));
`else
    // Window commands are ignored in the fixed-window build
    pq.delete();
    send_byte(8'h2A, 1'b0);
    send_byte(8'h00, 1'b1); send_byte(8'h0A, 1'b1);
    send_byte(8'h00, 1'b1); send_byte(8'h0B, 1'b1);
    send_byte(8'h2C, 1'b0);
    send_byte(8'h12, 1'b1); send_byte(8'h34, 1'b1);
    settle();
    pop_pix("fixed_win_pix", p);
    chk("fixed_win_pos", 64'({p.h, p.v}), 64'({8'd0, 7'd0}));
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
